// File: rtl/opl2_timer_ctrl_if.sv
// ============================================================================
// Module   : opl2_timer_ctrl_if
// Brief    : Host write bus of the OPL2 timer control block (address/data port,
//            status readback and busy indication).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface opl2_timer_ctrl_if;
    logic       bus_wr;
    logic       bus_a0;
    logic [7:0] bus_din;
    logic [7:0] bus_dout;
    logic       bus_busy;

    modport master (
        output bus_wr,
        output bus_a0,
        output bus_din,
        input  bus_dout,
        input  bus_busy
    );

    modport slave (
        input  bus_wr,
        input  bus_a0,
        input  bus_din,
        output bus_dout,
        output bus_busy
    );
endinterface

`default_nettype wire

// File: rtl/opl2_timer_ctrl.sv
// ============================================================================
// Module   : opl2_timer_ctrl
// Brief    : OPL2 host-bus front end: address/data decode with write wait-times,
//            timer registers 0x02-0x04, sticky overflow flags and IRQ.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module opl2_timer_ctrl #(
    parameter int ADDR_WAIT_CYCLES = 12,
    parameter int DATA_WAIT_CYCLES = 84
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    opl2_timer_ctrl_if.slave   bus,
    output logic               reg_wr,
    output logic [7:0]         reg_addr,
    output logic [7:0]         reg_data,
    output logic [7:0]         timer1_reg,
    output logic [7:0]         timer2_reg,
    output logic               start_timer1,
    output logic               start_timer2,
    input  wire logic          timer1_overflow_pulse,
    input  wire logic          timer2_overflow_pulse,
    output logic               irq_n
);

    localparam int c_MAX_WAIT = (ADDR_WAIT_CYCLES > DATA_WAIT_CYCLES) ?
                                ADDR_WAIT_CYCLES : DATA_WAIT_CYCLES;
    localparam int c_CNT_W    = (c_MAX_WAIT > 1) ? $clog2(c_MAX_WAIT) : 1;

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_ADDR_WAIT = 2'd1;
    localparam logic [1:0] c_DATA_WAIT = 2'd2;

    localparam logic [7:0] c_REG_T1   = 8'h02;
    localparam logic [7:0] c_REG_T2   = 8'h03;
    localparam logic [7:0] c_REG_CTRL = 8'h04;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_addr;
    logic               r_mask1;
    logic               r_mask2;
    logic               r_ft1;
    logic               r_ft2;

    logic w_accept;
    logic w_addr_wr;
    logic w_data_wr;
    logic w_irq_clr;
    logic w_irq;

    // Writes arriving during a wait are dropped without any side effect.
    assign w_accept  = bus.bus_wr && (r_state == c_IDLE);
    assign w_addr_wr = w_accept && !bus.bus_a0;
    assign w_data_wr = w_accept &&  bus.bus_a0;
    assign w_irq_clr = w_data_wr && (r_addr == c_REG_CTRL) && bus.bus_din[7];
    assign w_irq     = r_ft1 | r_ft2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_addr_wr) begin
                    w_next_state = c_ADDR_WAIT;
                end else if (w_data_wr) begin
                    w_next_state = c_DATA_WAIT;
                end
            end
            c_ADDR_WAIT, c_DATA_WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        bus.bus_busy = (r_state != c_IDLE);
    end

    // Loaded with WAIT-1 so the wait state lasts exactly WAIT cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_addr_wr) begin
            r_cnt <= c_CNT_W'(ADDR_WAIT_CYCLES - 1);
        end else if (w_data_wr) begin
            r_cnt <= c_CNT_W'(DATA_WAIT_CYCLES - 1);
        end else if ((r_state != c_IDLE) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr       <= 8'h00;
            reg_wr       <= 1'b0;
            reg_addr     <= 8'h00;
            reg_data     <= 8'h00;
            timer1_reg   <= 8'h00;
            timer2_reg   <= 8'h00;
            start_timer1 <= 1'b0;
            start_timer2 <= 1'b0;
            r_mask1      <= 1'b0;
            r_mask2      <= 1'b0;
        end else begin
            reg_wr <= w_data_wr;
            if (w_addr_wr) begin
                r_addr <= bus.bus_din;
            end
            if (w_data_wr) begin
                reg_addr <= r_addr;
                reg_data <= bus.bus_din;
                case (r_addr)
                    c_REG_T1: timer1_reg <= bus.bus_din;
                    c_REG_T2: timer2_reg <= bus.bus_din;
                    c_REG_CTRL: begin
                        if (!bus.bus_din[7]) begin
                            r_mask1      <= bus.bus_din[6];
                            r_mask2      <= bus.bus_din[5];
                            start_timer2 <= bus.bus_din[1];
                            start_timer1 <= bus.bus_din[0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // A new overflow beats a simultaneous clear; the mask in force before this edge applies.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ft1        <= 1'b0;
            r_ft2        <= 1'b0;
            irq_n        <= 1'b1;
            bus.bus_dout <= 8'h00;
        end else begin
            r_ft1        <= (timer1_overflow_pulse && !r_mask1) || (r_ft1 && !w_irq_clr);
            r_ft2        <= (timer2_overflow_pulse && !r_mask2) || (r_ft2 && !w_irq_clr);
            irq_n        <= !w_irq;
            bus.bus_dout <= {w_irq, r_ft1, r_ft2, 5'b00000};
        end
    end

endmodule

`default_nettype wire
